// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - ping-pong capture buffer draining an NxN result matrix row-major
// Captures one armed result matrix per arm into a free bank and streams it one element per beat.
module systolic_result_drain #(
  parameter int N      = 4,
  parameter int ELEM_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic                    i_validInput,
  input  logic                    i_validResult,
  input  logic [N*N*ELEM_W-1:0]   i_c,
  output logic [ELEM_W-1:0]       o_data,
  output logic [$clog2(N)-1:0]    o_row,
  output logic [$clog2(N)-1:0]    o_col,
  output logic                    o_valid,
  output logic                    o_last,
  input  logic                    i_ready,
  output logic                    o_overflow,
  input  logic                    i_clearOverflow
);

  localparam int NE    = N * N;
  localparam int IDX_W = $clog2(NE);
  localparam int RC_W  = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

  typedef logic [NE-1:0][ELEM_W-1:0] bank_t;

  bank_t            bank0_q;
  bank_t            bank1_q;
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic             wr_q;
  logic             rd_q;
  logic [IDX_W-1:0] idx_q;
  logic             armed_q;
  logic             overflow_q;

  bank_t rd_bank;
  logic  transfer;
  logic  last_beat;
  logic  final_xfer;
  logic  capture_req;
  logic  bank_free;
  logic  do_capture;
  logic  drop;

  always_comb begin
    rd_bank     = rd_q ? bank1_q : bank0_q;
    o_valid     = full_q[rd_q];
    transfer    = o_valid & i_ready;
    last_beat   = (idx_q == LAST_IDX);
    o_last      = o_valid & last_beat;
    final_xfer  = transfer & last_beat;
    capture_req = i_validResult & armed_q;
    // A bank draining its final beat this cycle can be refilled on the same edge.
    bank_free   = ~full_q[wr_q] | (final_xfer & (rd_q == wr_q));
    do_capture  = capture_req & bank_free;
    drop        = capture_req & ~bank_free;
    o_data      = rd_bank[idx_q];
    o_row       = RC_W'(idx_q / N);
    o_col       = RC_W'(idx_q % N);
    o_overflow  = overflow_q;
  end

  // Capture sets after the drain clears, so a same-bank refill stays full.
  always_comb begin
    full_d = full_q;
    if (final_xfer) full_d[rd_q] = 1'b0;
    if (do_capture) full_d[wr_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      bank0_q    <= '0;
      bank1_q    <= '0;
      full_q     <= 2'b00;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      idx_q      <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      full_q <= full_d;

      if (do_capture) begin
        if (wr_q) bank1_q <= i_c;
        else      bank0_q <= i_c;
        wr_q <= ~wr_q;
      end

      if (final_xfer) begin
        rd_q  <= ~rd_q;
        idx_q <= '0;
      end else if (transfer) begin
        idx_q <= idx_q + IDX_W'(1);
      end

      if (i_validInput)     armed_q <= 1'b1;
      else if (capture_req) armed_q <= 1'b0;

      if (drop)                 overflow_q <= 1'b1;
      else if (i_clearOverflow) overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - scoreboard bench for systolic_result_drain
// Expected beats are queued at capture time and compared as the DUT transfers them.
module tb_systolic_result_drain;

  localparam int N      = 4;
  localparam int ELEM_W = 16;

  typedef logic [N-1:0][N-1:0][ELEM_W-1:0] mat_t;
  typedef struct {
    logic [ELEM_W-1:0] data;
    logic [1:0]        row;
    logic [1:0]        col;
    logic              last;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              valid_input;
  logic              valid_result;
  mat_t              c_mat;
  logic [ELEM_W-1:0] data;
  logic [1:0]        row;
  logic [1:0]        col;
  logic              valid;
  logic              last;
  logic              ready;
  logic              overflow;
  logic              clear_overflow;

  int    total;
  int    bad;
  int    beats_seen;
  beat_t sb[$];

  logic              prev_stall;
  logic [ELEM_W-1:0] prev_data;
  logic [1:0]        prev_row;
  logic [1:0]        prev_col;

  systolic_result_drain #(.N(N), .ELEM_W(ELEM_W)) dut (
    .i_clk           (clk),
    .i_arst_n        (rst_n),
    .i_validInput    (valid_input),
    .i_validResult   (valid_result),
    .i_c             (c_mat),
    .o_data          (data),
    .o_row           (row),
    .o_col           (col),
    .o_valid         (valid),
    .o_last          (last),
    .i_ready         (ready),
    .o_overflow      (overflow),
    .i_clearOverflow (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer monitor: sampled on the falling edge, between input drives and the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (valid && prev_stall) begin
        total++;
        if (data !== prev_data || row !== prev_row || col !== prev_col) begin
          bad++;
          $display("FAIL stall_hold: got d=%h r=%0d c=%0d want d=%h r=%0d c=%0d",
                   data, row, col, prev_data, prev_row, prev_col);
        end
      end
      if (valid && ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got d=%h r=%0d c=%0d want no beat", data, row, col);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if (data !== e.data || row !== e.row || col !== e.col || last !== e.last) begin
            bad++;
            $display("FAIL beat: got d=%h r=%0d c=%0d l=%b want d=%h r=%0d c=%0d l=%b",
                     data, row, col, last, e.data, e.row, e.col, e.last);
          end
        end
        beats_seen++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_row   = row;
      prev_col   = col;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    valid_input = 1'b1;
    tick();
    valid_input = 1'b0;
  endtask

  // Pulses i_validResult for one cycle; queues the matrix when it is expected to be kept.
  task automatic pulse_result(input mat_t m, input bit keep);
    c_mat        = m;
    valid_result = 1'b1;
    if (keep) begin
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < N; k++) begin
          beat_t b;
          b.data = m[r][k];
          b.row  = 2'(r);
          b.col  = 2'(k);
          b.last = (r == N - 1) && (k == N - 1);
          sb.push_back(b);
        end
      end
    end
    tick();
    valid_result = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    tick();
  endtask

  function automatic mat_t ramp_mat(input int base);
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++)
        m[r][k] = 16'(base + r * N + k);
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++)
        m[r][k] = 16'($urandom);
    return m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if (valid !== 1'b0 || last !== 1'b0 || data !== 16'h0 || row !== 2'd0 || col !== 2'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h r=%0d c=%0d ov=%b want all zero",
               valid, last, data, row, col, overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ready = 1'b1;
    arm();
    repeat (9) tick();
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL pre_capture_valid: got %b want 0", valid);
    end
    pulse_result(ramp_mat(0), 1'b1);
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("FAIL capture_latency: got valid=%b want 1", valid);
    end
    wait_drain(100);
    total++;
    if (sb.size() != 0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: got left=%0d valid=%b want 0 0", sb.size(), valid);
    end
  endtask

  task automatic test_unarmed();
    ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      pulse_result(ramp_mat(100 * p), 1'b0);
      for (int i = 0; i < 15; i++) begin
        total++;
        if (valid !== 1'b0 || overflow !== 1'b0) begin
          bad++;
          $display("FAIL unarmed: got valid=%b ov=%b want 0 0", valid, overflow);
        end
        tick();
      end
    end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    arm();
    pulse_result(ramp_mat(16'h100), 1'b1);
    arm();
    pulse_result(ramp_mat(16'h200), 1'b1);
    total++;
    if (valid !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL both_full: got valid=%b ov=%b want 1 0", valid, overflow);
    end
    arm();
    pulse_result(ramp_mat(16'h300), 1'b0);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: got %b want 1", overflow);
    end
    arm();
    clear_overflow = 1'b1;
    pulse_result(ramp_mat(16'h400), 1'b0);
    clear_overflow = 1'b0;
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL set_beats_clear: got %b want 1", overflow);
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear: got %b want 0", overflow);
    end
    ready = 1'b1;
    wait_drain(200);
    total++;
    if (sb.size() != 0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL overflow_drain: got left=%0d valid=%b want 0 0", sb.size(), valid);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    ready = 1'b0;
    start = beats_seen;
    arm();
    pulse_result(ramp_mat(16'h500), 1'b1);
    arm();
    pulse_result(ramp_mat(16'h600), 1'b1);
    arm();
    ready = 1'b1;
    // Beats transfer on the next 16 edges; the result strobe lines up with the 16th.
    repeat (15) tick();
    pulse_result(ramp_mat(16'h700), 1'b1);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL final_beat_capture: got ov=%b want 0", overflow);
    end
    wait_drain(200);
    total++;
    if (beats_seen - start != 48 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got beats=%0d left=%0d want 48 0", beats_seen - start, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int i;
    ready = 1'b0;
    arm();
    pulse_result(rand_mat(), 1'b1);
    arm();
    pulse_result(rand_mat(), 1'b1);
    for (i = 0; i < 2000 && sb.size() != 0; i++) begin
      ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    ready = 1'b1;
    tick();
    total++;
    if (sb.size() != 0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_drain: got left=%0d valid=%b want 0 0", sb.size(), valid);
    end
  endtask

  task automatic test_reset_midstream();
    int target;
    int i;
    ready = 1'b1;
    target = beats_seen + 7;
    arm();
    pulse_result(ramp_mat(16'h800), 1'b1);
    for (i = 0; i < 100 && beats_seen < target; i++) @(negedge clk);
    total++;
    if (beats_seen < target) begin
      bad++;
      $display("FAIL midstream_timeout: got beats=%0d want %0d", beats_seen, target);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || data !== 16'h0 || row !== 2'd0 || col !== 2'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%b d=%h r=%0d c=%0d want 0 0 0 0", valid, data, row, col);
    end
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_result(ramp_mat(16'h900), 1'b0);
    for (i = 0; i < 20; i++) begin
      if (valid !== 1'b0) break;
      tick();
    end
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got valid=%b want 0", valid);
    end
    arm();
    pulse_result(ramp_mat(16'hA00), 1'b1);
    wait_drain(100);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL post_reset_stream: got left=%0d want 0", sb.size());
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    beats_seen     = 0;
    prev_stall     = 1'b0;
    rst_n          = 1'b0;
    valid_input    = 1'b0;
    valid_result   = 1'b0;
    c_mat          = '0;
    ready          = 1'b0;
    clear_overflow = 1'b0;
    test_reset();
    test_single();
    test_unarmed();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
